// File: rtl/uvc_payload_scheduler.sv
// UVC isochronous IN packet sequencer: 12-byte payload header then FIFO data; first TX_VAL_O 1 cycle after EP_REQ_I.
// Stalls on !TX_RDY_I with TX_DAT_O held; FIFO is only popped on an accepted data byte.
module uvc_payload_scheduler #(
  parameter int HEADER_LEN   = 12,
  parameter int PAYLOAD_SIZE = 1024,
  parameter int FRAME_SIZE   = 640*480*2
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic        EP_REQ_I,
  input  logic [7:0]  FIFO_DAT_I,
  input  logic        FIFO_EMPTY_I,
  input  logic [15:0] FIFO_CNT_I,
  output logic        FIFO_RD_O,
  input  logic [7:0]  FRAME_I,
  input  logic [31:0] PTS_I,
  input  logic [10:0] SOF_CNT_I,
  output logic [7:0]  TX_DAT_O,
  output logic        TX_VAL_O,
  input  logic        TX_RDY_I,
  output logic        TX_LAST_O,
  output logic [10:0] TX_LEN_O,
  output logic        BUSY_O
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HDR  = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [31:0] FRAME_LEN = 32'(FRAME_SIZE);
  localparam logic [31:0] MAX_DATA  = 32'(PAYLOAD_SIZE - HEADER_LEN);
  localparam logic [10:0] HDR_LEN11 = 11'(HEADER_LEN);
  localparam logic [3:0]  HDR_LAST  = 4'(HEADER_LEN - 1);

  logic [1:0]  state;
  logic [3:0]  idx;
  logic [15:0] dcnt;
  logic [15:0] n_r;
  logic        eof_r;
  logic        fid;
  logic [31:0] remain;
  logic [31:0] stc;
  logic [31:0] stc_l;
  logic [10:0] sof_l;
  logic [31:0] pts_r;

  logic [31:0] chunk;
  logic [15:0] n_next;
  logic        accept;
  logic [7:0]  hdr_byte;

  // FID is generated here, and empty can't occur in DATA since n never exceeds the FIFO count at request time.
  logic unused_inputs;
  assign unused_inputs = ^{FRAME_I, FIFO_EMPTY_I};

  assign chunk  = (remain < MAX_DATA) ? remain : MAX_DATA;
  assign n_next = ({16'd0, FIFO_CNT_I} >= chunk) ? chunk[15:0] : 16'd0;

  assign TX_VAL_O  = (state == ST_HDR) || (state == ST_DATA);
  assign accept    = TX_VAL_O && TX_RDY_I;
  assign FIFO_RD_O = (state == ST_DATA) && TX_RDY_I;
  assign BUSY_O    = (state != ST_IDLE);

  always_comb begin
    hdr_byte = 8'h00;
    case (idx)
      4'd0:    hdr_byte = 8'h0C;
      4'd1:    hdr_byte = 8'h8C | {6'd0, eof_r, fid};
      4'd2:    hdr_byte = pts_r[7:0];
      4'd3:    hdr_byte = pts_r[15:8];
      4'd4:    hdr_byte = pts_r[23:16];
      4'd5:    hdr_byte = pts_r[31:24];
      4'd6:    hdr_byte = stc_l[7:0];
      4'd7:    hdr_byte = stc_l[15:8];
      4'd8:    hdr_byte = stc_l[23:16];
      4'd9:    hdr_byte = stc_l[31:24];
      4'd10:   hdr_byte = sof_l[7:0];
      4'd11:   hdr_byte = {5'd0, sof_l[10:8]};
      default: hdr_byte = 8'h00;
    endcase
  end

  always_comb begin
    TX_DAT_O  = 8'h00;
    TX_LAST_O = 1'b0;
    case (state)
      ST_HDR: begin
        TX_DAT_O  = hdr_byte;
        TX_LAST_O = (idx == HDR_LAST) && (n_r == 16'd0);
      end
      ST_DATA: begin
        TX_DAT_O  = FIFO_DAT_I;
        TX_LAST_O = (dcnt == n_r - 16'd1);
      end
      default: begin
        TX_DAT_O  = 8'h00;
        TX_LAST_O = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      stc <= 32'd0;
    end else begin
      stc <= stc + 32'd1;
    end
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state    <= ST_IDLE;
      idx      <= 4'd0;
      dcnt     <= 16'd0;
      n_r      <= 16'd0;
      eof_r    <= 1'b0;
      fid      <= 1'b0;
      remain   <= FRAME_LEN;
      stc_l    <= 32'd0;
      sof_l    <= 11'd0;
      pts_r    <= 32'd0;
      TX_LEN_O <= 11'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (EP_REQ_I) begin
            n_r      <= n_next;
            TX_LEN_O <= HDR_LEN11 + n_next[10:0];
            stc_l    <= stc;
            sof_l    <= SOF_CNT_I;
            // PTS belongs to the frame, so only the first packet of a frame samples it.
            if (remain == FRAME_LEN) pts_r <= PTS_I;
            eof_r    <= (n_next != 16'd0) && ({16'd0, n_next} == remain);
            idx      <= 4'd0;
            dcnt     <= 16'd0;
            state    <= ST_HDR;
          end
        end
        ST_HDR: begin
          if (accept) begin
            if (idx == HDR_LAST) begin
              idx   <= 4'd0;
              state <= (n_r == 16'd0) ? ST_DONE : ST_DATA;
            end else begin
              idx <= idx + 4'd1;
            end
          end
        end
        ST_DATA: begin
          if (accept) begin
            if (dcnt == n_r - 16'd1) begin
              dcnt   <= 16'd0;
              remain <= remain - {16'd0, n_r};
              state  <= ST_DONE;
            end else begin
              dcnt <= dcnt + 16'd1;
            end
          end
        end
        default: begin
          if (eof_r) begin
            fid    <= ~fid;
            remain <= FRAME_LEN;
          end
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uvc_payload_scheduler.sv
// Directed bench for uvc_payload_scheduler with PAYLOAD_SIZE=32, FRAME_SIZE=40 (20 data bytes per full packet).
module tb_uvc_payload_scheduler;

  logic        CLK_I = 1'b0;
  logic        RST_I = 1'b1;
  logic        EP_REQ_I = 1'b0;
  logic [7:0]  FIFO_DAT_I;
  logic        FIFO_EMPTY_I;
  logic [15:0] FIFO_CNT_I;
  logic        FIFO_RD_O;
  logic [7:0]  FRAME_I = 8'h00;
  logic [31:0] PTS_I = 32'h0;
  logic [10:0] SOF_CNT_I = 11'h0;
  logic [7:0]  TX_DAT_O;
  logic        TX_VAL_O;
  logic        TX_RDY_I = 1'b1;
  logic        TX_LAST_O;
  logic [10:0] TX_LEN_O;
  logic        BUSY_O;

  int nvec = 0;
  int nerr = 0;

  // Bench-side FIFO model
  logic [7:0]  mem [0:255];
  logic [15:0] wr_ptr = 16'd0;
  logic [15:0] rd_ptr = 16'd0;
  int          exp_ptr = 0;

  assign FIFO_DAT_I   = mem[rd_ptr[7:0]];
  assign FIFO_CNT_I   = wr_ptr - rd_ptr;
  assign FIFO_EMPTY_I = (wr_ptr == rd_ptr);

  always @(posedge CLK_I) if (FIFO_RD_O) rd_ptr <= rd_ptr + 16'd1;

  always #5 CLK_I = ~CLK_I;

  uvc_payload_scheduler #(.HEADER_LEN(12), .PAYLOAD_SIZE(32), .FRAME_SIZE(40)) dut (
    .CLK_I(CLK_I), .RST_I(RST_I), .EP_REQ_I(EP_REQ_I),
    .FIFO_DAT_I(FIFO_DAT_I), .FIFO_EMPTY_I(FIFO_EMPTY_I), .FIFO_CNT_I(FIFO_CNT_I), .FIFO_RD_O(FIFO_RD_O),
    .FRAME_I(FRAME_I), .PTS_I(PTS_I), .SOF_CNT_I(SOF_CNT_I),
    .TX_DAT_O(TX_DAT_O), .TX_VAL_O(TX_VAL_O), .TX_RDY_I(TX_RDY_I), .TX_LAST_O(TX_LAST_O),
    .TX_LEN_O(TX_LEN_O), .BUSY_O(BUSY_O)
  );

  function automatic logic [7:0] byte_of(int k);
    return 8'((k * 37 + 11) & 255);
  endfunction

  task automatic push(input int cnt);
    for (int i = 0; i < cnt; i++) begin
      mem[wr_ptr[7:0]] = byte_of(int'(wr_ptr));
      wr_ptr = wr_ptr + 16'd1;
    end
  endtask

  // Packet capture results
  logic [7:0]  pkt [0:63];
  int          plen, lastpos, rdcnt, stall_bad;
  bit          done, rst_hit, lat_val, rst_val, rst_busy;
  logic [10:0] len_seen;

  task automatic capture(input bit toggle, input bit extra_req, input int rst_at);
    bit         started;
    bit         prev_stall;
    logic [7:0] prev_dat;
    plen = 0; lastpos = -1; rdcnt = 0; stall_bad = 0;
    done = 0; rst_hit = 0; lat_val = 0; rst_val = 1; rst_busy = 1; len_seen = 11'd0;
    started = 0; prev_stall = 0; prev_dat = 8'h00;
    for (int c = 0; c < 300; c++) begin
      @(negedge CLK_I);
      EP_REQ_I = (c == 0) || (extra_req && c == 3);
      TX_RDY_I = toggle ? (c % 2 == 1) : 1'b1;
      if (rst_at >= 0 && plen == rst_at) begin
        RST_I = 1'b1;
        #1;
        rst_hit = 1; rst_val = TX_VAL_O; rst_busy = BUSY_O;
        break;
      end
      #1;
      if (c == 1) begin lat_val = TX_VAL_O; len_seen = TX_LEN_O; end
      if (prev_stall && TX_VAL_O && TX_DAT_O !== prev_dat) stall_bad++;
      prev_stall = TX_VAL_O && !TX_RDY_I;
      prev_dat   = TX_DAT_O;
      if (FIFO_RD_O) rdcnt++;
      if (TX_VAL_O && TX_RDY_I && plen < 64) begin
        pkt[plen] = TX_DAT_O;
        if (TX_LAST_O) lastpos = plen;
        plen++;
      end
      if (TX_VAL_O) started = 1;
      else if (started) begin done = 1; break; end
    end
    EP_REQ_I = 1'b0;
    TX_RDY_I = 1'b1;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge CLK_I);
    #1;
    nvec++; if (TX_VAL_O !== 1'b0) begin nerr++; $display("FAIL reset_val got=%b want=0", TX_VAL_O); end
    nvec++; if (BUSY_O !== 1'b0) begin nerr++; $display("FAIL reset_busy got=%b want=0", BUSY_O); end
    nvec++; if (FIFO_RD_O !== 1'b0) begin nerr++; $display("FAIL reset_rd got=%b want=0", FIFO_RD_O); end
    nvec++; if (TX_LEN_O !== 11'd0) begin nerr++; $display("FAIL reset_len got=%0d want=0", TX_LEN_O); end
    nvec++; if ({TX_LAST_O, TX_DAT_O} !== 9'd0) begin nerr++; $display("FAIL reset_dat got=%h want=0", {TX_LAST_O, TX_DAT_O}); end
    @(negedge CLK_I);
    RST_I = 1'b0;
  endtask

  task automatic test_first_packet;
    PTS_I = 32'h11223344; SOF_CNT_I = 11'h5A3;
    push(40);
    capture(0, 0, -1);
    nvec++; if (done !== 1'b1) begin nerr++; $display("FAIL p1_done got=%b want=1", done); end
    nvec++; if (lat_val !== 1'b1) begin nerr++; $display("FAIL p1_latency got=%b want=1", lat_val); end
    nvec++; if (len_seen !== 11'd32) begin nerr++; $display("FAIL p1_txlen got=%0d want=32", len_seen); end
    nvec++; if (plen != 32) begin nerr++; $display("FAIL p1_bytes got=%0d want=32", plen); end
    nvec++; if (pkt[0] !== 8'h0C) begin nerr++; $display("FAIL p1_hle got=%h want=0c", pkt[0]); end
    nvec++; if (pkt[1] !== 8'h8C) begin nerr++; $display("FAIL p1_bfh got=%h want=8c", pkt[1]); end
    nvec++; if ({pkt[2], pkt[3], pkt[4], pkt[5]} !== 32'h44332211) begin nerr++;
      $display("FAIL p1_pts got=%h want=44332211", {pkt[2], pkt[3], pkt[4], pkt[5]}); end
    nvec++; if ({pkt[10], pkt[11]} !== 16'hA305) begin nerr++; $display("FAIL p1_sof got=%h want=a305", {pkt[10], pkt[11]}); end
    nvec++; if (lastpos != 31) begin nerr++; $display("FAIL p1_last got=%0d want=31", lastpos); end
    nvec++; if (rdcnt != 20) begin nerr++; $display("FAIL p1_pops got=%0d want=20", rdcnt); end
    for (int i = 0; i < 20; i++) begin
      nvec++; if (pkt[12+i] !== byte_of(exp_ptr + i)) begin nerr++;
        $display("FAIL p1_data[%0d] got=%h want=%h", i, pkt[12+i], byte_of(exp_ptr + i)); end
    end
    exp_ptr += 20;
  endtask

  task automatic test_eof_and_fid;
    PTS_I = 32'h55667788;
    capture(0, 0, -1);
    nvec++; if (pkt[1] !== 8'h8E) begin nerr++; $display("FAIL p2_bfh got=%h want=8e", pkt[1]); end
    nvec++; if ({pkt[2], pkt[5]} !== 16'h4411) begin nerr++; $display("FAIL p2_pts_held got=%h want=4411", {pkt[2], pkt[5]}); end
    nvec++; if (lastpos != 31) begin nerr++; $display("FAIL p2_last got=%0d want=31", lastpos); end
    for (int i = 0; i < 20; i++) begin
      nvec++; if (pkt[12+i] !== byte_of(exp_ptr + i)) begin nerr++;
        $display("FAIL p2_data[%0d] got=%h want=%h", i, pkt[12+i], byte_of(exp_ptr + i)); end
    end
    exp_ptr += 20;
    push(25);
    capture(0, 0, -1);
    nvec++; if (pkt[1] !== 8'h8D) begin nerr++; $display("FAIL p3_bfh got=%h want=8d", pkt[1]); end
    nvec++; if ({pkt[2], pkt[5]} !== 16'h8855) begin nerr++; $display("FAIL p3_pts_new got=%h want=8855", {pkt[2], pkt[5]}); end
    nvec++; if (plen != 32) begin nerr++; $display("FAIL p3_bytes got=%0d want=32", plen); end
    for (int i = 0; i < 20; i++) begin
      nvec++; if (pkt[12+i] !== byte_of(exp_ptr + i)) begin nerr++;
        $display("FAIL p3_data[%0d] got=%h want=%h", i, pkt[12+i], byte_of(exp_ptr + i)); end
    end
    exp_ptr += 20;
  endtask

  task automatic test_underrun;
    capture(0, 0, -1);
    nvec++; if (len_seen !== 11'd12) begin nerr++; $display("FAIL ur_txlen got=%0d want=12", len_seen); end
    nvec++; if (plen != 12) begin nerr++; $display("FAIL ur_bytes got=%0d want=12", plen); end
    nvec++; if (pkt[1] !== 8'h8D) begin nerr++; $display("FAIL ur_bfh got=%h want=8d", pkt[1]); end
    nvec++; if (rdcnt != 0) begin nerr++; $display("FAIL ur_pops got=%0d want=0", rdcnt); end
    nvec++; if (lastpos != 11) begin nerr++; $display("FAIL ur_last got=%0d want=11", lastpos); end
    nvec++; if (FIFO_CNT_I !== 16'd5) begin nerr++; $display("FAIL ur_fifo got=%0d want=5", FIFO_CNT_I); end
  endtask

  task automatic test_backpressure;
    push(15);
    capture(1, 0, -1);
    nvec++; if (done !== 1'b1) begin nerr++; $display("FAIL bp_done got=%b want=1", done); end
    nvec++; if (plen != 32) begin nerr++; $display("FAIL bp_bytes got=%0d want=32", plen); end
    nvec++; if (pkt[1] !== 8'h8F) begin nerr++; $display("FAIL bp_bfh got=%h want=8f", pkt[1]); end
    nvec++; if (rdcnt != 20) begin nerr++; $display("FAIL bp_pops got=%0d want=20", rdcnt); end
    nvec++; if (stall_bad != 0) begin nerr++; $display("FAIL bp_stall_hold got=%0d want=0", stall_bad); end
    for (int i = 0; i < 20; i++) begin
      nvec++; if (pkt[12+i] !== byte_of(exp_ptr + i)) begin nerr++;
        $display("FAIL bp_data[%0d] got=%h want=%h", i, pkt[12+i], byte_of(exp_ptr + i)); end
    end
    exp_ptr += 20;
  endtask

  task automatic test_req_during_hdr;
    int extra;
    PTS_I = 32'hA1B2C3D4;
    push(40);
    capture(0, 1, -1);
    nvec++; if (plen != 32) begin nerr++; $display("FAIL hq_bytes got=%0d want=32", plen); end
    nvec++; if (pkt[1] !== 8'h8C) begin nerr++; $display("FAIL hq_bfh got=%h want=8c", pkt[1]); end
    nvec++; if (pkt[2] !== 8'hD4) begin nerr++; $display("FAIL hq_pts got=%h want=d4", pkt[2]); end
    extra = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge CLK_I); #1;
      if (TX_VAL_O) extra++;
    end
    nvec++; if (extra != 0) begin nerr++; $display("FAIL hq_extra_pkt got=%0d want=0", extra); end
    nvec++; if (FIFO_CNT_I !== 16'd20) begin nerr++; $display("FAIL hq_fifo got=%0d want=20", FIFO_CNT_I); end
    exp_ptr += 20;
    capture(0, 0, -1);
    nvec++; if (pkt[1] !== 8'h8E) begin nerr++; $display("FAIL hq_eof_bfh got=%h want=8e", pkt[1]); end
    exp_ptr += 20;
  endtask

  task automatic test_reset_mid;
    push(40);
    capture(0, 0, 17);
    nvec++; if (rst_hit !== 1'b1) begin nerr++; $display("FAIL mr_reached got=%b want=1", rst_hit); end
    nvec++; if (rst_val !== 1'b0) begin nerr++; $display("FAIL mr_val got=%b want=0", rst_val); end
    nvec++; if (rst_busy !== 1'b0) begin nerr++; $display("FAIL mr_busy got=%b want=0", rst_busy); end
    repeat (3) @(negedge CLK_I);
    RST_I = 1'b0;
    repeat (5) @(negedge CLK_I);
    #1;
    nvec++; if (FIFO_CNT_I !== 16'd35) begin nerr++; $display("FAIL mr_fifo got=%0d want=35", FIFO_CNT_I); end
    exp_ptr += 5;
    capture(0, 0, -1);
    nvec++; if (pkt[1] !== 8'h8C) begin nerr++; $display("FAIL mr_bfh got=%h want=8c", pkt[1]); end
    nvec++; if (len_seen !== 11'd32) begin nerr++; $display("FAIL mr_txlen got=%0d want=32", len_seen); end
    nvec++; if (rdcnt != 20) begin nerr++; $display("FAIL mr_pops got=%0d want=20", rdcnt); end
    for (int i = 0; i < 20; i++) begin
      nvec++; if (pkt[12+i] !== byte_of(exp_ptr + i)) begin nerr++;
        $display("FAIL mr_data[%0d] got=%h want=%h", i, pkt[12+i], byte_of(exp_ptr + i)); end
    end
    exp_ptr += 20;
  endtask

  initial begin
    test_reset;
    test_first_packet;
    test_eof_and_fid;
    test_underrun;
    test_backpressure;
    test_req_during_hdr;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
